frame_dump_ctrl: RTL and testbench

- Parametrised frame-dump sequencer: on a debounced trigger, walks a COLS x ROWS word buffer (the downsample read port) and streams each word MSB-byte-first to the UART transmitter.
- Successor to the hard-wired 40x30x4 dump logic. Adds an optional sync/dimension header, continuous mode, abort, and status outputs.
- Sits in the sys_clk_i (12 MHz) domain, between the downsample read port and the uart instance.

---
 rtl/frame_dump_ctrl_pkg.sv | 18 +
 rtl/btn_debounce.sv | 38 +++
 rtl/frame_dump_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_frame_dump_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dump_ctrl_pkg.sv
// Shared constants for the frame-dump sequencer: FSM encodings, header length
// and the frame byte-count helper.
package frame_dump_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int HDR_LEN = 3;

    function automatic int frame_bytes(input int cols, input int rows,
                                       input int word_bytes, input int send_header);
        return HDR_LEN * send_header + cols * rows * word_bytes;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchroniser plus saturating release counter.
// pressed_o is high on the first synchronised-high cycle after a full release period.
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pressed_o
);

    logic [1:0]               sync_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic [DEBOUNCE_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sync_q[1]) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + DEBOUNCE_BITS'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
        end
    end

    // The counter clears on the cycle after the press is seen, so one press yields one pulse.
    assign pressed_o = sync_q[1] & (&cnt_q);

endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame-dump sequencer: walks a COLS x ROWS word buffer and streams each word
// MSB-byte-first to the UART, one byte per send_ok, optionally behind a 3-byte header.
module frame_dump_ctrl
    import frame_dump_ctrl_pkg::*;
#(
    parameter int         COLS          = 40,
    parameter int         ROWS          = 30,
    parameter int         WORD_BYTES    = 4,
    parameter int         X_BITS        = 6,
    parameter int         Y_BITS        = 5,
    parameter int         HOLDOFF_BITS  = 13,
    parameter int         DEBOUNCE_BITS = 14,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         SEND_HEADER   = 1
) (
    input  logic                    sys_clk_i,
    input  logic                    areset,
    input  logic                    trig_btn,
    input  logic                    continuous,
    input  logic                    abort,
    output logic [X_BITS-1:0]       read_x,
    output logic [Y_BITS-1:0]       read_y,
    input  logic [8*WORD_BYTES-1:0] read_q,
    input  logic                    uart_busy,
    output logic                    uart_write,
    output logic [7:0]              uart_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int WORD_W = 8 * WORD_BYTES;

    logic [2:0]              state_q, state_d;
    logic [X_BITS-1:0]       x_q, x_d;
    logic [Y_BITS-1:0]       y_q, y_d;
    logic [2:0]              bidx_q, bidx_d;
    logic                    fetch_wait_q, fetch_wait_d;
    logic [WORD_W-1:0]       shreg_q, shreg_d;
    logic                    wr_q, wr_d;
    logic [7:0]              data_q, data_d;
    logic                    done_q, done_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;

    logic       trig_pressed;
    logic       send_ok;
    logic       last_x;
    logic       last_word;
    logic [2:0] start_state;
    logic [7:0] hdr_byte;

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_btn_debounce (
        .clk_i    (sys_clk_i),
        .rst_i    (areset),
        .btn_i    (trig_btn),
        .pressed_o(trig_pressed)
    );

    always_comb begin
        hold_d = hold_q;
        if (uart_busy) begin
            hold_d = '0;
        end else if (!(&hold_q)) begin
            hold_d = hold_q + HOLDOFF_BITS'(1);
        end
    end

    assign send_ok     = (&hold_q) & ~uart_busy & ~wr_q;
    assign last_x      = (x_q == X_BITS'(COLS - 1));
    assign last_word   = last_x && (y_q == Y_BITS'(ROWS - 1));
    assign start_state = (SEND_HEADER != 0) ? ST_HDR : ST_FETCH;

    always_comb begin
        case (bidx_q)
            3'd0:    hdr_byte = SYNC_BYTE;
            3'd1:    hdr_byte = 8'(COLS);
            default: hdr_byte = 8'(ROWS);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        bidx_d       = bidx_q;
        fetch_wait_d = fetch_wait_q;
        shreg_d      = shreg_q;
        wr_d         = 1'b0;
        data_d       = data_q;
        done_d       = 1'b0;

        // Abort beats both send_ok and the DONE restart; a strobe already on the wire finishes.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            x_d          = '0;
            y_d          = '0;
            bidx_d       = '0;
            fetch_wait_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_pressed) begin
                        state_d      = start_state;
                        x_d          = '0;
                        y_d          = '0;
                        bidx_d       = '0;
                        fetch_wait_d = 1'b0;
                    end
                end
                ST_HDR: begin
                    if (send_ok) begin
                        wr_d   = 1'b1;
                        data_d = hdr_byte;
                        if (bidx_q == 3'(HDR_LEN - 1)) begin
                            bidx_d  = '0;
                            state_d = ST_FETCH;
                        end else begin
                            bidx_d = bidx_q + 3'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    // First cycle lets the registered buffer catch up with the new address.
                    if (!fetch_wait_q) begin
                        fetch_wait_d = 1'b1;
                    end else begin
                        fetch_wait_d = 1'b0;
                        shreg_d      = read_q;
                        state_d      = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (send_ok) begin
                        wr_d    = 1'b1;
                        data_d  = shreg_q[WORD_W-1 -: 8];
                        shreg_d = shreg_q << 8;
                        if (bidx_q == 3'(WORD_BYTES - 1)) begin
                            bidx_d = '0;
                            if (last_word) begin
                                x_d     = '0;
                                y_d     = '0;
                                state_d = ST_DONE;
                            end else begin
                                if (last_x) begin
                                    x_d = '0;
                                    y_d = y_q + Y_BITS'(1);
                                end else begin
                                    x_d = x_q + X_BITS'(1);
                                end
                                state_d = ST_FETCH;
                            end
                        end else begin
                            bidx_d = bidx_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_d       = 1'b1;
                    x_d          = '0;
                    y_d          = '0;
                    bidx_d       = '0;
                    fetch_wait_d = 1'b0;
                    state_d      = continuous ? start_state : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            bidx_q       <= '0;
            fetch_wait_q <= 1'b0;
            shreg_q      <= '0;
            wr_q         <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bidx_q       <= bidx_d;
            fetch_wait_q <= fetch_wait_d;
            shreg_q      <= shreg_d;
            wr_q         <= wr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
        end
    end

    assign read_x     = x_q;
    assign read_y     = y_q;
    assign uart_write = wr_q;
    assign uart_data  = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed bench for frame_dump_ctrl on a 2x2x2-byte buffer: header and no-header
// instances, UART pacing model, debounce, continuous, abort and async reset.
module tb_frame_dump_ctrl;

    logic        clk = 1'b0;
    logic        areset, trig_btn, continuous, abort;
    logic [0:0]  read_x, read_y;
    logic [15:0] read_q = '0;
    logic        uart_busy = 1'b0;
    logic        uart_write, frame_done, busy;
    logic [7:0]  uart_data;

    logic        areset2, trig2;
    logic        zero_in = 1'b0;
    logic [0:0]  read_x2, read_y2;
    logic [15:0] read_q2 = '0;
    logic        uart_write2, frame_done2, busy2;
    logic [7:0]  uart_data2;

    logic        pacing = 1'b0;
    int          tests = 0;
    int          fails = 0;

    logic [7:0]  wr1[$];
    logic [7:0]  wr2[$];
    int          fd1 = 0, fd2 = 0;
    int          viol = 0, dbl = 0;
    int          busy_left = 0, idle_cnt = 0, min_gap = 999;
    logic        seen_fall = 1'b0, prev_wr = 1'b0;

    logic [7:0]  exp_frame [11] = '{8'hA5, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00,
                                    8'h01, 8'h01, 8'h00, 8'h01, 8'h01};

    always #5 clk = ~clk;

    frame_dump_ctrl #(
        .COLS(2), .ROWS(2), .WORD_BYTES(2), .X_BITS(1), .Y_BITS(1),
        .HOLDOFF_BITS(2), .DEBOUNCE_BITS(3), .SYNC_BYTE(8'hA5), .SEND_HEADER(1)
    ) u_dut (
        .sys_clk_i(clk), .areset(areset), .trig_btn(trig_btn),
        .continuous(continuous), .abort(abort),
        .read_x(read_x), .read_y(read_y), .read_q(read_q),
        .uart_busy(uart_busy), .uart_write(uart_write), .uart_data(uart_data),
        .busy(busy), .frame_done(frame_done)
    );

    frame_dump_ctrl #(
        .COLS(2), .ROWS(2), .WORD_BYTES(2), .X_BITS(1), .Y_BITS(1),
        .HOLDOFF_BITS(2), .DEBOUNCE_BITS(3), .SYNC_BYTE(8'hA5), .SEND_HEADER(0)
    ) u_dut_nh (
        .sys_clk_i(clk), .areset(areset2), .trig_btn(trig2),
        .continuous(zero_in), .abort(zero_in),
        .read_x(read_x2), .read_y(read_y2), .read_q(read_q2),
        .uart_busy(zero_in), .uart_write(uart_write2), .uart_data(uart_data2),
        .busy(busy2), .frame_done(frame_done2)
    );

    // Buffer model: one cycle of read latency, word = {0y, 0x}.
    always @(posedge clk) begin
        read_q  <= {7'b0, read_y, 7'b0, read_x};
        read_q2 <= {7'b0, read_y2, 7'b0, read_x2};
    end

    // UART model and monitor for the header instance.
    always @(negedge clk) begin
        if (uart_write) begin
            wr1.push_back(uart_data);
            if (uart_busy) viol++;
            if (prev_wr) dbl++;
            if (pacing && seen_fall && idle_cnt < min_gap) min_gap = idle_cnt;
            if (pacing) begin
                uart_busy = 1'b1;
                busy_left = 20;
            end
        end else if (uart_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                uart_busy = 1'b0;
                idle_cnt  = 1;
                seen_fall = 1'b1;
            end
        end else begin
            idle_cnt++;
        end
        prev_wr = uart_write;
        if (frame_done) fd1++;
    end

    always @(negedge clk) begin
        if (uart_write2) wr2.push_back(uart_data2);
        if (frame_done2) fd2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        trig_btn = 1'b0;
        cyc(10);
        trig_btn = 1'b1;
        cyc(3);
        trig_btn = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target, input int budget);
        int n = 0;
        while (fd1 < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(fd1 >= target), 32'd1);
    endtask

    task automatic wait_wr(input string tag, input int target, input int budget);
        int n = 0;
        while (wr1.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(wr1.size() >= target), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int base);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(wr1[base + i]), 32'(exp_frame[i]));
    endtask

    initial begin
        int base, fdb, vb;
        areset = 1'b1; areset2 = 1'b1;
        trig_btn = 1'b1; trig2 = 1'b0;
        continuous = 1'b0; abort = 1'b0;
        cyc(3);
        check("rst_write", 32'(uart_write), 0);
        check("rst_data",  32'(uart_data), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(frame_done), 0);
        check("rst_x",     32'(read_x), 0);
        check("rst_y",     32'(read_y), 0);
        areset = 1'b0; areset2 = 1'b0;

        // Short release (3 cycles) must not trigger.
        cyc(5);
        trig_btn = 1'b0;
        cyc(3);
        trig_btn = 1'b1;
        cyc(30);
        check("deb_short_bytes", 32'(wr1.size()), 0);
        check("deb_short_busy",  32'(busy), 0);

        // Single frame, with a second press while busy.
        base = wr1.size(); fdb = fd1;
        press();
        wait_wr("single_wait5", base + 5, 200);
        trig_btn = 1'b0;
        cyc(10);
        check("press_in_busy", 32'(busy), 1);
        trig_btn = 1'b1;
        cyc(3);
        trig_btn = 1'b0;
        wait_fd("single_wait_done", fdb + 1, 300);
        cyc(30);
        check("single_count", 32'(wr1.size() - base), 32'(frame_dump_ctrl_pkg::frame_bytes(2, 2, 2, 1)));
        chk_frame("single", base);
        check("single_fd", 32'(fd1 - fdb), 1);
        check("single_busy", 32'(busy), 0);
        check("single_pulse", 32'(dbl), 0);

        // UART pacing.
        base = wr1.size(); fdb = fd1; vb = viol;
        pacing = 1'b1;
        press();
        wait_fd("pace_wait_done", fdb + 1, 2000);
        cyc(30);
        pacing = 1'b0;
        check("pace_count", 32'(wr1.size() - base), 11);
        chk_frame("pace", base);
        check("pace_viol", 32'(viol - vb), 0);
        check("pace_gap_ge4", 32'(min_gap >= 4), 1);

        // Continuous mode, dropped during frame 2.
        base = wr1.size(); fdb = fd1;
        continuous = 1'b1;
        press();
        wait_fd("cont_wait1", fdb + 1, 300);
        cyc(8);
        continuous = 1'b0;
        wait_fd("cont_wait2", fdb + 2, 300);
        cyc(40);
        check("cont_fd", 32'(fd1 - fdb), 2);
        check("cont_count", 32'(wr1.size() - base), 22);
        chk_frame("cont_f1", base);
        chk_frame("cont_f2", base + 11);
        check("cont_busy", 32'(busy), 0);

        // Abort after the 5th strobe, then a fresh frame.
        base = wr1.size(); fdb = fd1;
        press();
        wait_wr("abort_wait5", base + 5, 200);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(30);
        check("abort_count", 32'(wr1.size() - base), 5);
        check("abort_fd", 32'(fd1 - fdb), 0);
        check("abort_x", 32'(read_x), 0);
        check("abort_y", 32'(read_y), 0);
        check("abort_busy", 32'(busy), 0);
        base = wr1.size();
        press();
        wait_fd("abort_wait_new", fdb + 1, 300);
        cyc(20);
        check("abort_new_count", 32'(wr1.size() - base), 11);
        chk_frame("abort_new", base);

        // No-header instance: async reset mid-SEND, then a full 8-byte frame.
        trig2 = 1'b1;
        cyc(3);
        trig2 = 1'b0;
        begin
            int n = 0;
            while (wr2.size() < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("nh_wait3", 32'(wr2.size() >= 3), 1);
        end
        areset2 = 1'b1;
        #1;
        check("nh_rst_write", 32'(uart_write2), 0);
        check("nh_rst_data",  32'(uart_data2), 0);
        check("nh_rst_busy",  32'(busy2), 0);
        check("nh_rst_done",  32'(frame_done2), 0);
        check("nh_rst_x",     32'(read_x2), 0);
        check("nh_rst_y",     32'(read_y2), 0);
        @(negedge clk);
        areset2 = 1'b0;
        cyc(2);
        base = wr2.size(); fdb = fd2;
        cyc(12);
        trig2 = 1'b1;
        cyc(3);
        trig2 = 1'b0;
        begin
            int n = 0;
            while (fd2 < fdb + 1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("nh_wait_done", 32'(fd2 >= fdb + 1), 1);
        end
        cyc(20);
        check("nh_count", 32'(wr2.size() - base), 32'(frame_dump_ctrl_pkg::frame_bytes(2, 2, 2, 0)));
        for (int i = 0; i < 8; i++)
            check($sformatf("nh_b%0d", i), 32'(wr2[base + i]), 32'(exp_frame[i + 3]));
        check("nh_fd", 32'(fd2 - fdb), 1);
        check("nh_busy", 32'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
